// File: rtl/pmem_arb_pkg.sv
// pmem_arb_pkg: shared types and default widths for the pmem arbiter slice.
//   arb_state_t : arbiter FSM states
//   client_t    : identity of a line-port client (icache / dcache)
//   DEF_ADDR_W / DEF_LINE_W : default line address / line data widths
package pmem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    CLI_I = 1'b0,
    CLI_D = 1'b1
  } client_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: bundles the icache line port, the dcache line port and the
// physical memory port around the arbiter.
//   modport slave  : the arbiter's view (clients and memory response in,
//                    client responses and memory strobes out)
//   modport master : the environment's view (caches + physical memory)
//
// Handshake: a client raises read/write with address (and wdata) and holds
// them steady until its resp pulse; resp is a single-cycle completion with
// rdata valid in that same cycle. The memory side mirrors this: strobes stay
// high with stable address/wdata until pmem_resp pulses for one cycle.
interface pmem_arbiter_if
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
);

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/pmem_arb_rr2.sv
// pmem_arb_rr2: combinational two-way round-robin picker.
//   req_i, req_d : pending requests from icache / dcache
//   last_grant   : client served most recently
//   gnt_valid    : at least one request pending
//   gnt          : chosen client (the one not served last on a tie)
module pmem_arb_rr2
  import pmem_arb_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  client_t last_grant,
  output logic    gnt_valid,
  output client_t gnt
);

  assign gnt_valid = req_i | req_d;

  always_comb begin
    gnt = CLI_I;
    if (req_i && req_d) begin
      gnt = (last_grant == CLI_I) ? CLI_D : CLI_I;
    end else if (req_d) begin
      gnt = CLI_D;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: serializes whole-line icache/dcache transactions onto the
// single physical_memory port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pmem_arbiter_if.slave (both client ports + memory port)
//   dbg_state  : current FSM state, for observation only
// Requests are registered into the memory strobes (one cycle of arbitration
// latency); memory completion is forwarded combinationally to the owner.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  pmem_arbiter_if.slave bus,
  output arb_state_t    dbg_state
);

  arb_state_t        state_q, state_d;
  client_t           last_grant_q;
  logic              pmem_read_q;
  logic              pmem_write_q;
  logic [ADDR_W-1:0] pmem_address_q;
  logic [LINE_W-1:0] pmem_wdata_q;

  logic              req_d;
  logic              gnt_valid;
  client_t           gnt;
  logic              load;
  logic              done;

  assign req_d = bus.d_read | bus.d_write;

  pmem_arb_rr2 u_rr2 (
    .req_i      (bus.i_read),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // Other requests are not even looked at while serving, so the latched
  // address/wdata stay put for the whole strobe window.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          load    = 1'b1;
          state_d = (gnt == CLI_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= CLI_I;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        if (gnt == CLI_D) begin
          // A simultaneous read+write from the dcache is illegal; write wins.
          pmem_write_q   <= bus.d_write;
          pmem_read_q    <= ~bus.d_write;
          pmem_address_q <= bus.d_address;
          pmem_wdata_q   <= bus.d_write ? bus.d_wdata : '0;
        end else begin
          pmem_write_q   <= 1'b0;
          pmem_read_q    <= 1'b1;
          pmem_address_q <= bus.i_address;
          pmem_wdata_q   <= '0;
        end
      end else if (done) begin
        pmem_read_q  <= 1'b0;
        pmem_write_q <= 1'b0;
        last_grant_q <= (state_q == SERVE_D) ? CLI_D : CLI_I;
      end
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = pmem_wdata_q;

  // Read data is broadcast; only the completion pulse is steered, and a
  // pmem_resp arriving while IDLE reaches nobody.
  assign bus.i_rdata = bus.pmem_rdata;
  assign bus.d_rdata = bus.pmem_rdata;
  assign bus.i_resp  = (state_q == SERVE_I) && bus.pmem_resp;
  assign bus.d_resp  = (state_q == SERVE_D) && bus.pmem_resp;

  assign dbg_state = state_q;

  a_no_dcache_rw: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.d_read && bus.d_write));

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: self-checking bench for pmem_arbiter. The bench plays both
// caches and the physical memory. Expected memory transactions
// {client, write, address, wdata} are queued when requests are driven and
// popped when the memory model completes the transaction.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int LW = DEF_LINE_W;
  localparam int W  = 2 + AW + LW;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         hold_i;
  logic         hold_d;

  pmem_arbiter_if bus ();

  pmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n          = 1'b0;
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;
    hold_i         = 1'b0;
    hold_d         = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Wait (from a negedge) until a memory strobe is up; cycles counts negedges.
  task automatic wait_strobe(output int cycles);
    cycles = 0;
    while (!(bus.pmem_read || bus.pmem_write) && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Memory model: called on a negedge with the strobe up. Waits lat cycles,
  // watching that the request stays stable, then pulses pmem_resp with data.
  // The client whose resp fires drops its request unless told to hold it.
  task automatic mem_respond(input int lat, input logic [LW-1:0] data,
                             output logic stable, output logic ir,
                             output logic dr, output logic [LW-1:0] ird,
                             output logic [LW-1:0] drd,
                             output logic [W-1:0] obs,
                             output logic strobe_after);
    logic [AW-1:0] a0;
    logic [LW-1:0] w0;
    logic          r0, wr0;
    a0 = bus.pmem_address; w0 = bus.pmem_wdata;
    r0 = bus.pmem_read;    wr0 = bus.pmem_write;
    stable = 1'b1;
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (bus.pmem_address !== a0 || bus.pmem_wdata !== w0 ||
          bus.pmem_read !== r0 || bus.pmem_write !== wr0) stable = 1'b0;
    end
    bus.pmem_rdata = data;
    bus.pmem_resp  = 1'b1;
    #1;
    ir  = bus.i_resp;  dr  = bus.d_resp;
    ird = bus.i_rdata; drd = bus.d_rdata;
    obs = {bus.d_resp, wr0, a0, w0};
    if (bus.i_resp && !hold_i) bus.i_read = 1'b0;
    if (bus.d_resp && !hold_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    strobe_after   = bus.pmem_read | bus.pmem_write;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (dbg_state !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    checks++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00", {bus.pmem_read, bus.pmem_write});
    end
    checks++;
    if (bus.pmem_address !== '0 || bus.pmem_wdata !== '0) begin
      failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", bus.pmem_address, bus.pmem_wdata);
    end
    checks++;
    if ({bus.i_resp, bus.d_resp} !== 2'b00) begin
      failures++; $display("FAIL reset_resp got=%b exp=00", {bus.i_resp, bus.d_resp});
    end
  endtask

  task automatic test_single_iread();
    logic [LW-1:0] data = {4{32'hDEAD_BEEF}};
    logic stable, ir, dr, sa;
    logic [LW-1:0] ird, drd;
    logic [W-1:0] obs, exp_t;
    int cyc;
    bus.i_read = 1'b1; bus.i_address = 16'h0040;
    exp_q.push_back({1'b0, 1'b0, 16'h0040, {LW{1'b0}}});
    #1;
    checks++;
    if (bus.pmem_read !== 1'b0) begin
      failures++; $display("FAIL iread_early got=%b exp=0", bus.pmem_read);
    end
    wait_strobe(cyc);
    checks++;
    if (cyc !== 1 || bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0040) begin
      failures++; $display("FAIL iread_strobe got=cyc%0d rd%b a%h exp=cyc1 rd1 a0040", cyc, bus.pmem_read, bus.pmem_address);
    end
    mem_respond(5, data, stable, ir, dr, ird, drd, obs, sa);
    checks++;
    if ({ir, dr} !== 2'b10 || ird !== data) begin
      failures++; $display("FAIL iread_resp got=%b/%h exp=10/%h", {ir, dr}, ird, data);
    end
    exp_t = exp_q.pop_front();
    checks++;
    if (obs !== exp_t || stable !== 1'b1) begin
      failures++; $display("FAIL iread_txn got=%h st%b exp=%h st1", obs, stable, exp_t);
    end
    #1;
    checks++;
    if ({bus.i_resp, bus.d_resp, sa} !== 3'b000) begin
      failures++; $display("FAIL iread_after got=%b exp=000", {bus.i_resp, bus.d_resp, sa});
    end
  endtask

  task automatic test_dwrite();
    logic [LW-1:0] wd = {2{64'h0123_4567_89AB_CDEF}};
    logic stable, ir, dr, sa;
    logic [LW-1:0] ird, drd;
    logic [W-1:0] obs, exp_t;
    int cyc;
    @(negedge clk);
    bus.d_write = 1'b1; bus.d_address = 16'h0100; bus.d_wdata = wd;
    exp_q.push_back({1'b1, 1'b1, 16'h0100, wd});
    wait_strobe(cyc);
    checks++;
    if (cyc !== 1 || {bus.pmem_write, bus.pmem_read} !== 2'b10) begin
      failures++; $display("FAIL dwrite_strobe got=cyc%0d wr/rd=%b exp=cyc1 10", cyc, {bus.pmem_write, bus.pmem_read});
    end
    mem_respond(4, rand_line(), stable, ir, dr, ird, drd, obs, sa);
    checks++;
    if ({ir, dr} !== 2'b01) begin
      failures++; $display("FAIL dwrite_resp got=%b exp=01", {ir, dr});
    end
    exp_t = exp_q.pop_front();
    checks++;
    if (obs !== exp_t || stable !== 1'b1) begin
      failures++; $display("FAIL dwrite_txn got=%h st%b exp=%h st1", obs, stable, exp_t);
    end
    checks++;
    if (sa !== 1'b0) begin
      failures++; $display("FAIL dwrite_strobe_clear got=%b exp=0", sa);
    end
  endtask

  task automatic test_tie_alternation();
    logic stable, ir, dr, sa;
    logic [LW-1:0] ird, drd, data;
    logic [W-1:0] obs, exp_t;
    int cyc;
    apply_reset();
    hold_i = 1'b1; hold_d = 1'b1;
    bus.i_read = 1'b1; bus.i_address = 16'h0200;
    bus.d_read = 1'b1; bus.d_address = 16'h0300;
    exp_q.push_back({1'b1, 1'b0, 16'h0300, {LW{1'b0}}});
    exp_q.push_back({1'b0, 1'b0, 16'h0200, {LW{1'b0}}});
    exp_q.push_back({1'b1, 1'b0, 16'h0300, {LW{1'b0}}});
    for (int n = 0; n < 3; n++) begin
      wait_strobe(cyc);
      checks++;
      if (cyc !== 1) begin
        failures++; $display("FAIL tie_gap txn%0d got=%0d exp=1", n, cyc);
      end
      data = rand_line();
      mem_respond($urandom_range(0, 4), data, stable, ir, dr, ird, drd, obs, sa);
      exp_t = exp_q.pop_front();
      checks++;
      if (obs !== exp_t || (ir ^ dr) !== 1'b1 || stable !== 1'b1) begin
        failures++; $display("FAIL tie_order txn%0d got=%h resp%b st%b exp=%h", n, obs, {ir, dr}, stable, exp_t);
      end
      checks++;
      if (ird !== data || drd !== data || sa !== 1'b0) begin
        failures++; $display("FAIL tie_data txn%0d got=%h/%h sa%b exp=%h sa0", n, ird, drd, sa, data);
      end
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    hold_i = 1'b0; hold_d = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00 || dbg_state !== IDLE) begin
      failures++; $display("FAIL tie_quiet got=%b st%0d exp=00 st0", {bus.pmem_read, bus.pmem_write}, dbg_state);
    end
  endtask

  task automatic test_request_during_service();
    logic stable, ir, dr, sa;
    logic [LW-1:0] ird, drd, wd;
    logic [W-1:0] obs, exp_t;
    int cyc;
    wd = rand_line();
    bus.d_write = 1'b1; bus.d_address = 16'h0400; bus.d_wdata = wd;
    exp_q.push_back({1'b1, 1'b1, 16'h0400, wd});
    exp_q.push_back({1'b0, 1'b0, 16'h0500, {LW{1'b0}}});
    wait_strobe(cyc);
    repeat (2) @(negedge clk);
    bus.i_read = 1'b1; bus.i_address = 16'h0500;
    mem_respond(3, rand_line(), stable, ir, dr, ird, drd, obs, sa);
    exp_t = exp_q.pop_front();
    checks++;
    if (obs !== exp_t || stable !== 1'b1 || {ir, dr} !== 2'b01) begin
      failures++; $display("FAIL svc_dwrite got=%h st%b resp%b exp=%h st1 resp01", obs, stable, {ir, dr}, exp_t);
    end
    wait_strobe(cyc);
    checks++;
    if (cyc !== 1 || bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0500) begin
      failures++; $display("FAIL svc_istart got=cyc%0d rd%b a%h exp=cyc1 rd1 a0500", cyc, bus.pmem_read, bus.pmem_address);
    end
    mem_respond(2, rand_line(), stable, ir, dr, ird, drd, obs, sa);
    exp_t = exp_q.pop_front();
    checks++;
    if (obs !== exp_t || {ir, dr} !== 2'b10) begin
      failures++; $display("FAIL svc_iread got=%h resp%b exp=%h resp10", obs, {ir, dr}, exp_t);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus.d_read = 1'b1; bus.d_address = 16'h0600;
    wait_strobe(cyc);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.d_read = 1'b0;
    #1;
    checks++;
    if ({bus.pmem_read, bus.pmem_write} !== 2'b00 || bus.pmem_address !== '0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL rstmid_async got=%b a%h st%0d exp=00 a0000 st0", {bus.pmem_read, bus.pmem_write}, bus.pmem_address, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.pmem_rdata = rand_line();
    bus.pmem_resp  = 1'b1;
    #1;
    checks++;
    if ({bus.i_resp, bus.d_resp} !== 2'b00) begin
      failures++; $display("FAIL rstmid_resp got=%b exp=00", {bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    checks++;
    if (dbg_state !== IDLE || {bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      failures++; $display("FAIL rstmid_idle got=st%0d %b exp=st0 00", dbg_state, {bus.pmem_read, bus.pmem_write});
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    bus.pmem_rdata = rand_line();
    bus.pmem_resp  = 1'b1;
    #1;
    checks++;
    if ({bus.i_resp, bus.d_resp} !== 2'b00) begin
      failures++; $display("FAIL spur_resp got=%b exp=00", {bus.i_resp, bus.d_resp});
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    checks++;
    if (dbg_state !== IDLE || {bus.pmem_read, bus.pmem_write} !== 2'b00) begin
      failures++; $display("FAIL spur_state got=st%0d %b exp=st0 00", dbg_state, {bus.pmem_read, bus.pmem_write});
    end
  endtask

  task automatic test_back_to_back();
    logic stable, ir, dr, sa, cli, wr;
    logic [LW-1:0] ird, drd, data, wd;
    logic [AW-1:0] addr;
    logic [W-1:0] obs, exp_t;
    int cyc;
    for (int n = 0; n < 6; n++) begin
      cli  = 1'($urandom_range(0, 1));
      wr   = cli ? 1'($urandom_range(0, 1)) : 1'b0;
      addr = AW'($urandom_range(0, 16'hFFFF));
      wd   = rand_line();
      if (cli) begin
        bus.d_read = ~wr; bus.d_write = wr; bus.d_address = addr; bus.d_wdata = wd;
      end else begin
        bus.i_read = 1'b1; bus.i_address = addr;
      end
      exp_q.push_back({cli, wr, addr, wr ? wd : {LW{1'b0}}});
      wait_strobe(cyc);
      data = rand_line();
      mem_respond($urandom_range(0, 3), data, stable, ir, dr, ird, drd, obs, sa);
      exp_t = exp_q.pop_front();
      checks++;
      if (cyc !== 1 || obs !== exp_t || {ir, dr} !== {~cli, cli} || stable !== 1'b1) begin
        failures++; $display("FAIL b2b_txn%0d got=cyc%0d %h resp%b exp=cyc1 %h", n, cyc, obs, {ir, dr}, exp_t);
      end
      checks++;
      if ((cli ? drd : ird) !== data || sa !== 1'b0) begin
        failures++; $display("FAIL b2b_data%0d got=%h sa%b exp=%h sa0", n, cli ? drd : ird, sa, data);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_iread();
    test_dwrite();
    test_tie_alternation();
    test_request_during_service();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-client arbiter between the instruction cache and data cache line ports and the single `physical_memory` port. It serializes whole-line (128-bit) transactions with a registered request path and a round-robin tie-break. Responses are forwarded combinationally to the owning client. It sits directly upstream of `physical_memory`, replacing the direct `pmem_*` hookup used by `mp0`.

## Interface
- `ADDR_W`, 16, line address width
- `LINE_W`, 128, line data width

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `i_read`  in  1  icache line read request, held until `i_resp`
- `i_address`  in  ADDR_W  icache line address
- `i_rdata`  out  LINE_W  icache read data, valid with `i_resp`
- `i_resp`  out  1  icache completion, one-cycle pulse
- `d_read`  in  1  dcache line read request, held until `d_resp`
- `d_write`  in  1  dcache line write request, held until `d_resp`
- `d_address`  in  ADDR_W  dcache line address
- `d_wdata`  in  LINE_W  dcache write line
- `d_rdata`  out  LINE_W  dcache read data, valid with `d_resp`
- `d_resp`  out  1  dcache completion, one-cycle pulse
- `pmem_read`, `pmem_write`  out  1  memory strobes, registered
- `pmem_address`  out  ADDR_W  registered
- `pmem_wdata`  out  LINE_W  registered
- `pmem_rdata`  in  LINE_W  memory read data
- `pmem_resp`  in  1  memory completion pulse

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE, no requests: stay in IDLE. Strobes are 0.
- IDLE, one requester: grant it.
- IDLE, both requesting: grant the client not served last (`last_grant` register).
- On grant, latch the address, wdata and op into the pmem registers, assert the strobe, and enter SERVE_x.
- SERVE_x: hold the pmem registers constant. Ignore other client requests.
- SERVE_x with `pmem_resp`=1 in the same cycle:
  - forward `x_resp`=1;
  - `x_rdata` = `pmem_rdata` (pass-through);
  - update `last_grant` to x;
  - next state IDLE, with strobes cleared at that edge.
- `i_rdata` and `d_rdata` always carry `pmem_rdata`. Only `x_resp` is gated by ownership.
- `pmem_resp` seen in IDLE (stale or spurious) is dropped: no client resp.
- `d_read` and `d_write` both high: protocol violation. Write wins, and a simulation assertion fires.
- A client that drops its request mid-transaction: the transaction still completes, and the resp pulse is still forwarded.
- Reset (async, any state) forces:
  - state to IDLE;
  - all strobes, `pmem_address` and `pmem_wdata` to 0;
  - `last_grant` to I, so the first tie goes to D.
- `i_resp`/`d_resp` are 0 whenever the state is IDLE or `pmem_resp` is 0.

## Timing
- Request sampled at edge t in IDLE → `pmem_read`/`pmem_write` high from t+1. This adds 1 cycle of arbitration latency.
- `pmem_resp` in cycle k → `x_resp` in cycle k, with zero added latency.
- FSM is in IDLE at k+1, with strobes low. The earliest next grant is edge k+1, giving strobes at k+2.
- Minimum back-to-back spacing is one idle strobe cycle between transactions. This guarantees the client sees its resp before re-arbitration.
- `physical_memory` must see stable `pmem_address`/`pmem_wdata` for the whole strobe window.

## Structure
- Package `pmem_arb_pkg`:
  - `arb_state_t` enum {IDLE, SERVE_I, SERVE_D};
  - `client_t` enum {CLI_I, CLI_D};
  - default `ADDR_W`/`LINE_W` localparams.
- Sub-module `pmem_arb_rr2`: a combinational two-way round-robin picker. Inputs are `req_i`, `req_d` and `last_grant`. Outputs are `gnt_valid` and `gnt`.
- The FSM, latch registers and response gating live in `pmem_arbiter`.

## Test plan
- **Single icache read.** Stimulus: `i_read`=1, `i_address`=16'h0040; memory returns `128'hDEAD_BEEF…` after 5 cycles. Required: `pmem_read` rises 1 cycle after the request, and `pmem_address`=16'h0040. `i_resp` pulses for one cycle with matching `i_rdata`, and `d_resp` stays 0.
- **Dcache write.** Stimulus: `d_write`=1, `d_address`=16'h0100, `d_wdata`=128'h0123…CDEF. Required: `pmem_write`=1 with identical address and wdata held until `pmem_resp`. `d_resp` pulses and `pmem_write` is 0 the next cycle.
- **Tie after reset, then alternation.**
  - Stimulus: `i_read` and `d_read` asserted together from reset and held (each re-asserted after its resp).
  - Required: the D transaction is served first, then I, then D.
  - Required: exactly one idle-strobe cycle between consecutive transactions.
- **Request during service.** Stimulus: `i_read` arrives while a D write is in flight. Required: `pmem_address` is unchanged until `d_resp`. The I read starts 2 cycles after the D resp.
- **Reset mid-transaction.**
  - Stimulus: `rst_n`=0 during SERVE_D; the memory then pulses `pmem_resp` after release.
  - Required: strobes drop immediately, without waiting for an edge.
  - Required: no `d_resp` pulse, and the FSM returns to IDLE.
- **Spurious response.** Stimulus: `pmem_resp`=1 while IDLE. Required: `i_resp`=`d_resp`=0 and the state is unchanged.
